btn_debounce_multi: RTL and testbench

- Multi-channel button conditioner for the Pacman board inputs (up/down/left/right/centre); successor to the single-button slow-clock flop chain.
- Synchronises each raw pushbutton to `clk` and filters it with a per-channel stable-sample counter driven by a shared clock-enable tick. No derived clock is used.
- Outputs a clean level, plus one-cycle press and release pulses per channel, to the game-control FSM.

---
 rtl/btn_debounce_multi.sv | 132 +++++++++++++
 tb/tb_btn_debounce_multi.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// Multi-channel pushbutton conditioner: 2-flop synchroniser, shared sample tick, per-channel
// stable-sample filter with press/release pulses. Define BTN_AUTOREPEAT_EN for held-button repeat.
module btn_debounce_multi #(
    parameter int unsigned N_CH       = 5,
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned SAMPLE_HZ  = 400,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned REP_DELAY  = 200,
    parameter int unsigned REP_RATE   = 40
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic            sample_tick
);

    localparam int unsigned DIV = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW  = (STABLE_CNT > 0) ? $clog2(STABLE_CNT + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    if (DIV < 2 || STABLE_CNT < 1 || REP_DELAY < 1 || REP_RATE < 1) begin : g_bad_cfg
        $error("btn_debounce_multi: invalid parameter set");
    end

    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [PW-1:0]   pre_q, pre_d;
    logic            tick_q;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] press_q, press_d, press_all;
    logic [N_CH-1:0] rel_q, rel_d;

    always_comb begin
        pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick_q) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i]   = '0;
                    level_d[i] = sync2_q[i];
                    press_d[i] = sync2_q[i];
                    rel_d[i]   = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int unsigned RW      = $clog2(REP_MAX + 1);

    logic [RW-1:0]   rep_q [N_CH];
    logic [RW-1:0]   rep_d [N_CH];
    logic [N_CH-1:0] armed_q, armed_d, rep_hit;

    // rep counts ticks since the last press pulse; armed selects first delay vs. repeat period
    always_comb begin
        rep_hit = '0;
        armed_d = armed_q;
        for (int i = 0; i < N_CH; i++) begin
            rep_d[i] = rep_q[i];
            if (!level_q[i] || (level_d[i] != level_q[i])) begin
                rep_d[i]   = '0;
                armed_d[i] = 1'b0;
            end else if (tick_q) begin
                if (32'(rep_q[i]) + 32'd1 == (armed_q[i] ? REP_RATE : REP_DELAY)) begin
                    rep_hit[i] = 1'b1;
                    rep_d[i]   = '0;
                    armed_d[i] = 1'b1;
                end else begin
                    rep_d[i] = rep_q[i] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= '0;
            for (int i = 0; i < N_CH; i++) rep_q[i] <= '0;
        end else begin
            armed_q <= armed_d;
            for (int i = 0; i < N_CH; i++) rep_q[i] <= rep_d[i];
        end
    end

    assign press_all = press_d | rep_hit;
`else
    assign press_all = press_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            tick_q  <= (pre_q == PRE_LAST);
            level_q <= level_d;
            press_q <= press_all;
            rel_q   <= rel_d;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = rel_q;
    assign sample_tick = tick_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Scoreboard bench for btn_debounce_multi: a tick-window reference model predicts pulse events,
// a monitor pops and compares them; directed phases check latency, bounce, reset and repeat.
module tb_btn_debounce_multi;

    localparam int unsigned N_CH       = 5;
    localparam int unsigned CLK_HZ     = 1000;
    localparam int unsigned SAMPLE_HZ  = 100;
    localparam int unsigned STABLE_CNT = 4;
    localparam int unsigned REP_DELAY  = 6;
    localparam int unsigned REP_RATE   = 3;
    localparam int          DIV        = CLK_HZ / SAMPLE_HZ;
    // edges from a clean raw change to the press: capture edge, 2-edge sync, wait for a tick,
    // then STABLE_CNT-1 further ticks of agreement
    localparam int          LAT_MIN    = 3 + (STABLE_CNT - 1) * DIV;
    localparam int          LAT_MAX    = LAT_MIN + DIV - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] btn_raw = '0;
    logic [N_CH-1:0] btn_level, btn_press, btn_release;
    logic            sample_tick;

    btn_debounce_multi #(
        .N_CH      (N_CH),
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ),
        .STABLE_CNT(STABLE_CNT),
        .REP_DELAY (REP_DELAY),
        .REP_RATE  (REP_RATE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              e;
        logic [N_CH-1:0] press;
        logic [N_CH-1:0] rel;
    } ev_t;

    ev_t             sb_q[$];
    int              checks = 0;
    int              errors = 0;
    int              e_now = 0;
    logic [N_CH-1:0] m_level = '0;
    logic            m_tick = 1'b0;
    logic [N_CH-1:0] raw_hist[$];
    logic [N_CH-1:0] tick_smp[$];
    int              since[N_CH];

    // Reference model: a level flips once the last STABLE_CNT tick samples all disagree with it
    initial begin
        logic [N_CH-1:0] pr, rl, s;
        bit              stable;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                e_now   = 0;
                m_level = '0;
                m_tick  = 1'b0;
                raw_hist.delete();
                raw_hist.push_back('0);
                raw_hist.push_back('0);
                tick_smp.delete();
                sb_q.delete();
                for (int c = 0; c < N_CH; c++) since[c] = 0;
            end else begin
                e_now++;
                raw_hist.push_back(btn_raw);
                pr = '0;
                rl = '0;
                if (m_tick) begin
                    s = raw_hist[e_now-1];
                    tick_smp.push_back(s);
                    if (tick_smp.size() > STABLE_CNT) void'(tick_smp.pop_front());
                    for (int c = 0; c < N_CH; c++) begin
                        stable = (tick_smp.size() == STABLE_CNT);
                        foreach (tick_smp[k]) if (tick_smp[k][c] == m_level[c]) stable = 0;
                        if (stable) begin
                            m_level[c] = ~m_level[c];
                            if (m_level[c]) pr[c] = 1'b1;
                            else            rl[c] = 1'b1;
                            since[c] = 0;
                        end else if (m_level[c]) begin
                            since[c]++;
`ifdef BTN_AUTOREPEAT_EN
                            if (since[c] == REP_DELAY ||
                                (since[c] > REP_DELAY && (since[c] - REP_DELAY) % REP_RATE == 0))
                                pr[c] = 1'b1;
`endif
                        end
                    end
                end
                m_tick = (e_now % DIV == 0);
                if ((pr | rl) != '0) sb_q.push_back('{e_now, pr, rl});
            end
        end
    end

    // Monitor
    initial begin
        ev_t ev;
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (sample_tick !== m_tick) begin
                errors++;
                $display("FAIL tick e=%0d: got %b expected %b", e_now, sample_tick, m_tick);
            end
            checks++;
            if (btn_level !== m_level) begin
                errors++;
                $display("FAIL level e=%0d: got %b expected %b", e_now, btn_level, m_level);
            end
            while (sb_q.size() > 0 && sb_q[0].e < e_now) begin
                ev = sb_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event e=%0d: got none expected press %b release %b",
                         ev.e, ev.press, ev.rel);
            end
            if (btn_press != '0 || btn_release != '0) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event e=%0d: got press %b release %b expected none",
                             e_now, btn_press, btn_release);
                end else begin
                    ev = sb_q.pop_front();
                    if (ev.e != e_now || ev.press !== btn_press || ev.rel !== btn_release) begin
                        errors++;
                        $display("FAIL event e=%0d: got press %b release %b, expected e=%0d %b %b",
                                 e_now, btn_press, btn_release, ev.e, ev.press, ev.rel);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_pulse(input int ch, input bit rel, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk);
            #1;
            if ((rel ? btn_release[ch] : btn_press[ch]) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n, first, ticks, cnt, exp_reps;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // idle: tick cadence and quiet outputs
        first = -1; ticks = 0; cnt = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (sample_tick) begin
                ticks++;
                if (first < 0) first = c;
            end
            if (btn_level != '0 || btn_press != '0 || btn_release != '0) cnt++;
        end
        chk("first_tick", first, DIV, DIV);
        chk("idle_ticks", ticks, 100 / DIV, 100 / DIV);
        chk("idle_outputs", cnt, 0, 0);

        // ch0 clean press, held to observe auto-repeat when enabled
        @(negedge clk);
        btn_raw[0] = 1'b1;
        wait_pulse(0, 1'b0, 80, n);
        chk("ch0_latency", n, LAT_MIN, LAT_MAX);
        exp_reps = 0;
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 1; k <= 16; k++)
            if (k == REP_DELAY || (k > REP_DELAY && (k - REP_DELAY) % REP_RATE == 0)) exp_reps++;
`endif
        cnt = 0;
        for (int c = 1; c <= 16 * DIV; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) chk("ch0_press_width", int'(btn_press[0]), 0, 0);
            if (btn_press[0]) cnt++;
        end
        chk("ch0_repeats", cnt, exp_reps, exp_reps);
        @(negedge clk);
        btn_raw[0] = 1'b0;
        wait_pulse(0, 1'b1, 80, n);
        chk("ch0_release_seen", n, 1, 80);
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (btn_press[0]) cnt++;
        end
        chk("ch0_no_press_after_release", cnt, 0, 0);

        // ch1 bounces with a 15-cycle half period, then holds
        cnt = 0;
        for (int c = 0; c < 210; c++) begin
            @(negedge clk);
            if (c % 15 == 0) btn_raw[1] = ~btn_raw[1];
            @(posedge clk);
            #1;
            if (btn_press[1] || btn_level[1]) cnt++;
        end
        chk("ch1_bounce_quiet", cnt, 0, 0);
        @(negedge clk);
        btn_raw[1] = 1'b1;
        wait_pulse(1, 1'b0, 80, n);
        chk("ch1_latency", n, LAT_MIN, LAT_MAX);
        @(negedge clk);
        btn_raw[1] = 1'b0;
        wait_pulse(1, 1'b1, 80, n);
        chk("ch1_release_seen", n, 1, 80);

        // ch2 and ch4 together
        @(negedge clk);
        btn_raw[2] = 1'b1;
        btn_raw[4] = 1'b1;
        wait_pulse(2, 1'b0, 80, n);
        chk("ch2_latency", n, LAT_MIN, LAT_MAX);
        chk("ch4_press_coincident", int'(btn_press[4]), 1, 1);
        @(negedge clk);
        btn_raw[2] = 1'b0;
        btn_raw[4] = 1'b0;
        wait_pulse(2, 1'b1, 80, n);
        chk("ch2_release_seen", n, 1, 80);
        chk("ch4_release_coincident", int'(btn_release[4]), 1, 1);

        // ch3: reset with a partial count, raw held through reset
        wait_pulse(0, 1'b0, 0, n);
        n = -1;
        for (int c = 0; c < 2 * DIV; c++) begin
            @(posedge clk);
            #1;
            if (sample_tick) begin
                n = c;
                break;
            end
        end
        chk("tick_found", n, 0, 2 * DIV);
        @(negedge clk);
        btn_raw[3] = 1'b1;
        repeat (25) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", int'({btn_level, btn_press, btn_release, sample_tick}), 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ticks = 0; n = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (btn_press[3]) begin
                n = c;
                break;
            end
            if (sample_tick) ticks++;
        end
        chk("ch3_press_after_reset", n, 1, 100);
        chk("ch3_ticks_to_press", ticks, STABLE_CNT, STABLE_CNT);
        @(negedge clk);
        btn_raw[3] = 1'b0;
        wait_pulse(3, 1'b1, 80, n);
        chk("ch3_release_seen", n, 1, 80);

        // randomized mixed activity across all channels
        for (int seg = 0; seg < 50; seg++) begin
            @(negedge clk);
            btn_raw = N_CH'($urandom);
            repeat ($urandom_range(5, 70)) @(negedge clk);
        end
        btn_raw = '0;
        repeat (120) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
